pixel_src: RTL and testbench
============================

Name: pixel_src

Overview:
- Upstream responder (SLAVE) for the pixel req/ack stream consumed by pipeline stages such as the V-channel adjuster on their receive (MASTER) port.
- A host-side writer loads pixels into an internal FIFO.
- The block answers the downstream master's req with ack-qualified pixels, one per accepted cycle.
- Tracks raster position and flags end-of-line and end-of-frame.

Parameters:
- DW, 8, pixel data width.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries.
- H_PIX, 640, pixels per line (>=1).
- V_LIN, 480, lines per frame (>=1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- xrst  in  1  reset, synchronous, active-high (xrst=1 resets on next rising edge).
- wr_en  in  1  host write strobe.
- wr_data  in  DW  host pixel.
- full  out  1  FIFO full; a write while full is dropped.
- level  out  DEPTH_LOG2+1  FIFO occupancy.
- snd_req  in  1  downstream master requests a pixel this cycle.
- snd_ack  out  1  registered; pixel_out valid this cycle.
- pixel_out  out  DW  registered pixel data.
- eol  out  1  registered; high with the ack of the last pixel of a line.
- eof  out  1  registered; high with the ack of the last pixel of a frame.

Behaviour:
- Reset values:
  - snd_ack=0, pixel_out=0, eol=0, eof=0, full=0, level=0.
  - Read/write pointers=0; x_cnt=0, y_cnt=0.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit pointers and a separate occupancy counter.
  - Write accepted iff wr_en && !full.
  - Read ("pop") iff snd_req && (level!=0).
  - Simultaneous accepted write and pop: level unchanged, both pointers advance.
  - Pop from empty never occurs.
  - A write to an empty FIFO is not poppable in the same cycle; it is first visible to pop on the next cycle (no fall-through).
  - full = (level == 2**DEPTH_LOG2).
- Handshake:
  - snd_req sampled at edge N with pop condition true: at N+1, snd_ack=1 and pixel_out=head entry, for exactly one cycle. Latency is 1 cycle.
  - snd_req held high with data available: ack on every cycle (full throughput).
  - snd_req=1 with FIFO empty: snd_ack=0 next cycle and pixel_out holds its previous value (underrun; no state change).
  - snd_req=0: snd_ack=0 next cycle; pixel_out holds.
- Raster state machine (states ACTIVE, LINE_END, FRAME_END, encoded by x_cnt/y_cnt):
  - On each pop, x_cnt increments.
  - Popping pixel x_cnt==H_PIX-1: eol=1 with that ack, x_cnt wraps to 0, y_cnt increments.
  - Also y_cnt==V_LIN-1: eof=1 (eol also 1), y_cnt wraps to 0.
  - eol/eof are 0 on all other cycles.
  - H_PIX=1: every ack carries eol=1.
- Reset mid-frame: all of the above clear on the next edge; FIFO contents discarded; the next acked pixel is x=0, y=0.
- Widths:
  - x_cnt is clog2(H_PIX) bits; y_cnt is clog2(V_LIN) bits.
  - Wrap compares are exact equality, never natural overflow.

Optional Feature:
- Macro PIXEL_SRC_UNDERRUN_EN.
- When defined, adds two outputs:
  - underrun (1 bit, sticky): set on any cycle with snd_req=1 && level==0; cleared only by xrst.
  - underrun_cnt (16 bits): increments on the same condition and saturates at 16'hFFFF.
- When undefined, neither port exists and the datapath is identical.

Test Plan:
- Reset then idle: xrst=1 for 2 cycles, then snd_req=0 -> snd_ack=0, pixel_out=0, level=0, full=0, eol=0, eof=0.
- Single transfer: write 8'hA5 at cycle 0, snd_req=1 at cycle 1 -> snd_ack=1 with pixel_out=8'hA5 at cycle 2; level back to 0 at cycle 2.
- Full/drop: DEPTH_LOG2=2, write 5 values 1..5 with no req -> full=1 after 4, level=4, value 5 dropped; snd_req held 4 cycles -> acks deliver 1,2,3,4 on consecutive cycles, then snd_ack=0.
- Simultaneous read/write at level=2: wr_en and snd_req both high for 3 cycles -> level stays 2; output order matches write order.
- Raster flags: H_PIX=3, V_LIN=2, stream 6 pixels -> eol on pixels 3 and 6; eof only on pixel 6; the 7th pixel restarts at x=0, y=0 (eol on the 9th).
- Underrun (macro defined): snd_req=1 for 3 cycles on an empty FIFO -> no ack, underrun=1, underrun_cnt=3. Mid-frame xrst -> counts and flags clear; the next frame's first pixel gets no eol.

Source files
------------

// File: rtl/pixel_src.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_src
//  Purpose  : Upstream pixel responder. A host writer fills an internal FIFO;
//             the downstream master pulls pixels with snd_req and receives
//             them one cycle later qualified by snd_ack. Raster position is
//             tracked so the last pixel of each line/frame is flagged.
//  Ports    : clk, xrst (sync, active-high)
//             wr_en, wr_data, full, level          host write side
//             snd_req, snd_ack, pixel_out, eol, eof downstream pull side
//             underrun, underrun_cnt               only with PIXEL_SRC_UNDERRUN_EN
//  Options  : `define PIXEL_SRC_UNDERRUN_EN adds the underrun monitor outputs.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_src #(
  parameter int DW         = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int H_PIX      = 640,
  parameter int V_LIN      = 480
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic                  wr_en,
  input  logic [DW-1:0]         wr_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  snd_req,
  output logic                  snd_ack,
  output logic [DW-1:0]         pixel_out,
  output logic                  eol,
  output logic                  eof
`ifdef PIXEL_SRC_UNDERRUN_EN
  ,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  // A 1-pixel line or 1-line frame still needs a 1-bit counter to exist.
  localparam int XW    = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW    = (V_LIN > 1) ? $clog2(V_LIN) : 1;

  localparam logic [LW-1:0]         FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [XW-1:0]         X_LAST   = XW'(H_PIX - 1);
  localparam logic [YW-1:0]         Y_LAST   = YW'(V_LIN - 1);
  localparam logic [XW-1:0]         X_ONE    = XW'(1);
  localparam logic [YW-1:0]         Y_ONE    = YW'(1);

  // --------------------------------------------------------------------------
  // FIFO storage and control
  // --------------------------------------------------------------------------
  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  pop;

  assign full   = (level == FULL_LVL);
  assign wr_acc = wr_en && !full;
  // Pop looks at the registered level, so a same-cycle write to an empty
  // FIFO cannot fall through.
  assign pop    = snd_req && (level != '0);

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Raster tracking: the state is decoded from the position counters, which
  // form the state register.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    LINE_END  = 2'd1,
    FRAME_END = 2'd2
  } raster_t;

  raster_t       pos_state;
  logic [XW-1:0] x_cnt, x_nxt;
  logic [YW-1:0] y_cnt, y_nxt;
  logic          eol_nxt, eof_nxt;

  always_comb begin
    pos_state = ACTIVE;
    if (x_cnt == X_LAST) begin
      pos_state = (y_cnt == Y_LAST) ? FRAME_END : LINE_END;
    end
  end

  always_comb begin
    x_nxt   = x_cnt;
    y_nxt   = y_cnt;
    eol_nxt = 1'b0;
    eof_nxt = 1'b0;
    if (pop) begin
      case (pos_state)
        ACTIVE: x_nxt = x_cnt + X_ONE;
        LINE_END: begin
          x_nxt   = '0;
          y_nxt   = y_cnt + Y_ONE;
          eol_nxt = 1'b1;
        end
        FRAME_END: begin
          x_nxt   = '0;
          y_nxt   = '0;
          eol_nxt = 1'b1;
          eof_nxt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      snd_ack   <= 1'b0;
      pixel_out <= '0;
      eol       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      x_cnt   <= x_nxt;
      y_cnt   <= y_nxt;
      snd_ack <= pop;
      eol     <= eol_nxt;
      eof     <= eof_nxt;
      if (pop) pixel_out <= mem[rd_ptr];
    end
  end

`ifdef PIXEL_SRC_UNDERRUN_EN
  // --------------------------------------------------------------------------
  // Underrun monitor: request against an empty FIFO.
  // --------------------------------------------------------------------------
  logic under_evt;
  assign under_evt = snd_req && (level == '0);

  always_ff @(posedge clk) begin
    if (xrst) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (under_evt) begin
      underrun <= 1'b1;
      if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_src.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_src
//  Purpose  : Self-checking bench for pixel_src. A queue-based model holds
//             the FIFO contents and a running pop count gives the raster
//             position; every cycle all outputs are compared to it.
//  Ports    : none (top level)
//  Options  : honours PIXEL_SRC_UNDERRUN_EN to check the underrun outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_src;

  localparam int DW    = 8;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int HP    = 3;
  localparam int VL    = 2;

  logic          clk = 1'b0;
  logic          xrst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full;
  logic [DL2:0]  level;
  logic          snd_req = 1'b0;
  logic          snd_ack;
  logic [DW-1:0] pixel_out;
  logic          eol;
  logic          eof;
`ifdef PIXEL_SRC_UNDERRUN_EN
  logic          underrun;
  logic [15:0]   underrun_cnt;
`endif

  pixel_src #(.DW(DW), .DEPTH_LOG2(DL2), .H_PIX(HP), .V_LIN(VL)) dut (
    .clk       (clk),
    .xrst      (xrst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .level     (level),
    .snd_req   (snd_req),
    .snd_ack   (snd_ack),
    .pixel_out (pixel_out),
    .eol       (eol),
    .eof       (eof)
`ifdef PIXEL_SRC_UNDERRUN_EN
    ,
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  int            pops;
  logic [DW-1:0] m_pix;
  logic          m_ack, m_eol, m_eof;
  logic          m_und;
  int            m_und_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("snd_ack",   32'(snd_ack),   32'(m_ack));
    chk("pixel_out", 32'(pixel_out), 32'(m_pix));
    chk("eol",       32'(eol),       32'(m_eol));
    chk("eof",       32'(eof),       32'(m_eof));
    chk("level",     32'(level),     32'(q.size()));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
`ifdef PIXEL_SRC_UNDERRUN_EN
    chk("underrun",     32'(underrun),     32'(m_und));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_und_cnt));
`endif
  endtask

  task automatic do_reset();
    xrst = 1'b1; wr_en = 1'b0; snd_req = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    xrst = 1'b0;
    q.delete();
    pops = 0; m_pix = '0; m_ack = 1'b0; m_eol = 1'b0; m_eof = 1'b0;
    m_und = 1'b0; m_und_cnt = 0;
    check_all();
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    int lvl;
    lvl = q.size();
    wr_en = w; wr_data = d; snd_req = r;
    m_ack = r && (lvl != 0);
    m_eol = 1'b0; m_eof = 1'b0;
    if (m_ack) begin
      m_pix = q.pop_front();
      m_eol = (pops % HP) == HP - 1;
      m_eof = m_eol && (((pops / HP) % VL) == VL - 1);
      pops++;
    end
    if (w && lvl < DEPTH) q.push_back(d);
    if (r && lvl == 0) begin
      m_und = 1'b1;
      if (m_und_cnt < 65535) m_und_cnt++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // Reset then idle
    do_reset();
    cycle(1'b0, 8'h00, 1'b0);

    // Single transfer
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Fill past full: value 5 is dropped, then drain 4 plus one underrun
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // Simultaneous read/write with level at 2, then drain
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);

    // Raster flags across a frame wrap
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1);

    // Underrun on empty, then mid-frame reset restarts at x=0,y=0
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h61, 1'b0);
    cycle(1'b1, 8'h62, 1'b1);
    do_reset();
    cycle(1'b1, 8'h71, 1'b0);
    cycle(1'b1, 8'h72, 1'b1);
    cycle(1'b1, 8'h73, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    // Randomised traffic, with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
